// File: rtl/tray_controller.sv
// tray_controller: frame-synchronous tray motion controller for the catch game.
// Decodes the latest keycode into left/right moves, accelerates once per frame,
// clamps at the walls and publishes the tray position and catch window.
//
// Ports:
//   Clk           in   1  system clock
//   Reset         in   1  synchronous active-high reset
//   frame_clk     in   1  frame strobe level; its rising edge is a frame tick
//   keycode       in   8  current keycode, sampled on frame ticks only
//   tray_position out 10  tray left edge in pixels
//   tray_min      out 10  same as tray_position
//   tray_max      out 10  tray_position + TRAY_WIDTH - 1
//   speed         out  4  current per-frame step, 0..STEP_MAX
//   wall_hit      out  1  one-cycle pulse when a move was clamped
module tray_controller #(
   parameter int unsigned TRAY_WIDTH = 64,
   parameter int unsigned X_MIN      = 0,
   parameter int unsigned X_MAX      = 639,
   parameter int unsigned START_X    = 288,
   parameter int unsigned STEP_MAX   = 8,
   parameter logic [7:0]  KEY_LEFT   = 8'h04,
   parameter logic [7:0]  KEY_RIGHT  = 8'h07
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] tray_position,
   output logic [9:0] tray_min,
   output logic [9:0] tray_max,
   output logic [3:0] speed,
   output logic       wall_hit
);

   localparam int unsigned X_RIGHT = X_MAX - TRAY_WIDTH + 1;
   localparam logic signed [10:0] LIM_LO = 11'(X_MIN);
   localparam logic signed [10:0] LIM_HI = 11'(X_RIGHT);
   localparam logic [3:0] SPEED_CAP = 4'(STEP_MAX);

   typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

   state_t state;
   logic   frame_q;
   logic   tick;
   logic   req_l;
   logic   req_r;
   logic [3:0]         speed_new;
   logic signed [10:0] pos_s;
   logic signed [10:0] step_s;
   logic signed [10:0] cand;
   logic signed [10:0] clamped;
   logic [9:0]         new_pos;
   logic               hit;

   assign tick  = frame_clk & ~frame_q;
   assign req_l = (keycode == KEY_LEFT);
   assign req_r = (keycode == KEY_RIGHT) & ~req_l;

   // Next step size, candidate position (signed, so no wrap) and wall clamp.
   always_comb begin
      speed_new = 4'd0;
      if (req_l) begin
         if (state == MOVE_L)
            speed_new = (speed < SPEED_CAP) ? speed + 4'd1 : SPEED_CAP;
         else
            speed_new = 4'd1;
      end else if (req_r) begin
         if (state == MOVE_R)
            speed_new = (speed < SPEED_CAP) ? speed + 4'd1 : SPEED_CAP;
         else
            speed_new = 4'd1;
      end

      pos_s  = signed'({1'b0, tray_position});
      step_s = signed'({7'b0, speed_new});
      cand   = req_l ? (pos_s - step_s) : (pos_s + step_s);

      if (cand < LIM_LO)
         clamped = LIM_LO;
      else if (cand > LIM_HI)
         clamped = LIM_HI;
      else
         clamped = cand;

      // A tray already parked at the wall still yields an out-of-range
      // candidate (step >= 1), so this also covers pushing into the wall.
      hit     = (req_l | req_r) & (clamped != cand);
      new_pos = 10'(clamped);
   end

   // State machine and registered outputs; updates only on frame ticks.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         frame_q       <= 1'b0;
         tray_position <= 10'(START_X);
         tray_min      <= 10'(START_X);
         tray_max      <= 10'(START_X + TRAY_WIDTH - 1);
         speed         <= 4'd0;
         wall_hit      <= 1'b0;
      end else begin
         frame_q  <= frame_clk;
         wall_hit <= 1'b0;
         if (tick) begin
            if (!req_l && !req_r) begin
               state <= IDLE;
               speed <= 4'd0;
            end else begin
               state         <= req_l ? MOVE_L : MOVE_R;
               tray_position <= new_pos;
               tray_min      <= new_pos;
               tray_max      <= new_pos + 10'(TRAY_WIDTH - 1);
               speed         <= hit ? 4'd1 : speed_new;
               wall_hit      <= hit;
            end
         end
      end
   end

endmodule

// File: tb/tb_tray_controller.sv
// Self-checking bench for tray_controller: directed sequence plus random frames,
// compared against a behavioural model of the tray motion rules.
module tb_tray_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [9:0] tray_position;
   logic [9:0] tray_min;
   logic [9:0] tray_max;
   logic [3:0] speed;
   logic       wall_hit;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: position, speed and direction (-1, 0, +1).
   int m_pos;
   int m_speed;
   int m_dir;
   int exp_hit;

   tray_controller dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .keycode       (keycode),
      .tray_position (tray_position),
      .tray_min      (tray_min),
      .tray_max      (tray_max),
      .speed         (speed),
      .wall_hit      (wall_hit)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pos   = 288;
      m_speed = 0;
      m_dir   = 0;
      exp_hit = 0;
   endtask

   task automatic model_step(input logic [7:0] key);
      int dir, s, c;
      dir     = (key == 8'h04) ? -1 : (key == 8'h07) ? 1 : 0;
      exp_hit = 0;
      if (dir == 0) begin
         m_dir   = 0;
         m_speed = 0;
      end else begin
         s = (dir == m_dir) ? ((m_speed + 1 > 8) ? 8 : m_speed + 1) : 1;
         c = m_pos + dir * s;
         if (c < 0) begin
            m_pos = 0;   exp_hit = 1;
         end else if (c > 576) begin
            m_pos = 576; exp_hit = 1;
         end else begin
            m_pos = c;
         end
         m_speed = (exp_hit != 0) ? 1 : s;
         m_dir   = dir;
      end
   endtask

   task automatic check_model(input string tag, input int hit);
      chk({tag, ".pos"},   32'(tray_position), 32'(m_pos));
      chk({tag, ".min"},   32'(tray_min),      32'(m_pos));
      chk({tag, ".max"},   32'(tray_max),      32'(m_pos + 63));
      chk({tag, ".speed"}, 32'(speed),         32'(m_speed));
      chk({tag, ".hit"},   32'(wall_hit),      32'(hit));
   endtask

   // One frame: rising frame_clk for two cycles, then low for gap cycles.
   // Keycode is scrambled after the tick cycle to show it is ignored.
   task automatic frame(input logic [7:0] key, input int gap, input string tag);
      @(negedge Clk);
      keycode   = key;
      frame_clk = 1'b1;
      model_step(key);
      @(negedge Clk);
      check_model(tag, exp_hit);
      keycode = 8'($urandom);
      @(negedge Clk);
      check_model({tag, ".after"}, 0);
      frame_clk = 1'b0;
      repeat (gap) begin
         @(negedge Clk);
         keycode = 8'($urandom);
      end
   endtask

   function automatic logic [7:0] rand_key();
      case ($urandom_range(0, 3))
         0:       return 8'h04;
         1:       return 8'h07;
         2:       return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int p0;
      Reset     = 1'b1;
      frame_clk = 1'b0;
      keycode   = 8'h00;
      model_reset();

      // Reset values
      repeat (2) @(negedge Clk);
      check_model("reset", 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      // Acceleration to the step limit
      frame(8'h07, 2, "accel1");
      chk("accel1.abs", 32'(tray_position), 32'd289);
      frame(8'h07, 2, "accel2");
      chk("accel2.abs", 32'(tray_position), 32'd291);
      frame(8'h07, 2, "accel3");
      chk("accel3.abs", 32'(tray_position), 32'd294);
      chk("accel3.spd", 32'(speed), 32'd3);
      for (int i = 4; i <= 10; i++) frame(8'h07, 3, "accel");
      chk("accel10.spd", 32'(speed), 32'd8);
      chk("accel10.abs", 32'(tray_position), 32'd340);

      // Long frame level: exactly one update
      @(negedge Clk);
      keycode   = 8'h07;
      frame_clk = 1'b1;
      model_step(8'h07);
      repeat (1000) begin
         @(negedge Clk);
         keycode = 8'($urandom);
      end
      check_model("long_level", 0);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);

      // Direction reversal then idle
      frame(8'h00, 2, "rev.idle");
      for (int i = 0; i < 4; i++) frame(8'h07, 2, "rev.r");
      chk("rev.spd4", 32'(speed), 32'd4);
      p0 = m_pos;
      frame(8'h04, 2, "rev.l");
      chk("rev.delta", 32'(tray_position), 32'(p0 - 1));
      chk("rev.spd1", 32'(speed), 32'd1);
      frame(8'h00, 2, "rev.stop");
      chk("rev.nomove", 32'(tray_position), 32'(p0 - 1));

      // Left wall: drive into it and keep pushing
      for (int i = 0; i < 60; i++) frame(8'h04, 1, "lwall");
      chk("lwall.pos0", 32'(tray_position), 32'd0);

      // Right wall
      for (int i = 0; i < 90; i++) frame(8'h07, 1, "rwall");
      chk("rwall.max", 32'(tray_max), 32'd639);

      // Random frames
      for (int i = 0; i < 300; i++) frame(rand_key(), $urandom_range(0, 5), "rand");

      // Reset in the same cycle as a tick, mid-move
      for (int i = 0; i < 3; i++) frame(8'h07, 1, "pre_rst");
      @(negedge Clk);
      keycode   = 8'h07;
      frame_clk = 1'b1;
      Reset     = 1'b1;
      @(negedge Clk);
      model_reset();
      check_model("rst_tick", 0);
      // frame_clk still high at release: first post-reset cycle is a tick
      Reset = 1'b0;
      model_step(8'h07);
      @(negedge Clk);
      check_model("post_rst_tick", exp_hit);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      frame(8'h07, 2, "post_rst2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tray_controller.md
# tray_controller

Frame-synchronous tray motion controller for the catch game. It decodes the latest keyboard keycode from the USB/NIOS path into left and right movement. It applies per-frame acceleration and wall clamping, and publishes the tray's position and catch window. Those outputs feed the falling-object logic (`tray_position`, `tray_min`, `tray_max`) and the colour mapper.

## Interface
Parameters:
- `TRAY_WIDTH`, default 64: tray width in pixels.
- `X_MIN`, default 0: leftmost legal left-edge position.
- `X_MAX`, default 639: rightmost screen pixel.
- `START_X`, default 288: left edge after reset.
- `STEP_MAX`, default 8: maximum pixels moved per frame.
- `KEY_LEFT`, default 8'h04: keycode for the A key.
- `KEY_RIGHT`, default 8'h07: keycode for the D key.

Ports:
- `Clk`, in, 1: system clock, 50 MHz.
- `Reset`, in, 1: synchronous, active-high reset.
- `frame_clk`, in, 1: frame strobe (VGA VS), asynchronous level; only its rising edge matters.
- `keycode`, in, 8: current keycode, sampled at frame ticks only.
- `tray_position`, out, 10: tray left edge in pixels.
- `tray_min`, out, 10: equals `tray_position`.
- `tray_max`, out, 10: `tray_position + TRAY_WIDTH - 1`.
- `speed`, out, 4: current per-frame step, 0 to `STEP_MAX`.
- `wall_hit`, out, 1: one-cycle pulse when a move was clamped.

## Operation
- **Edge detect:** `frame_q` registers `frame_clk` every cycle. `tick = frame_clk & ~frame_q`. A level held high for many cycles produces exactly one tick.
- **State machine:** states are IDLE, MOVE_L and MOVE_R. Transitions are evaluated only on `tick`. Between ticks, every register holds its value.
  - On tick, the direction request is:
    - `keycode == KEY_LEFT` → L
    - `keycode == KEY_RIGHT` → R
    - any other value → none
  - Request none: go to IDLE, `speed` ← 0, position unchanged.
  - Request L from MOVE_L: `speed` ← min(`speed` + 1, `STEP_MAX`).
  - Request L from IDLE or MOVE_R: `speed` ← 1, state ← MOVE_L.
  - Request R: mirror of the L rules.
- **Position arithmetic:** use an 11-bit signed intermediate so there is no wrap-around.
  - Candidate position is `pos - speed_new` (L) or `pos + speed_new` (R).
  - Legal range is `X_MIN` to `X_RIGHT = X_MAX - TRAY_WIDTH + 1` (576 with defaults).
  - A candidate outside the range clamps to the nearest limit.
- **Wall hit:** if clamping changed the value, or the tray was already at the limit in the requested direction:
  - `wall_hit` pulses for 1 cycle.
  - `speed` ← 1; the state stays MOVE_L or MOVE_R.
- **Outputs:** `tray_min` and `tray_max` are registered and update on the same edge as `tray_position`. They are never computed combinationally from stale values.

## Timing
- **Reset values** (at the first rising `Clk` edge with `Reset` = 1):
  - `tray_position` = `tray_min` = `START_X` (288)
  - `tray_max` = 351
  - `speed` = 0, `wall_hit` = 0
  - state IDLE, `frame_q` = 0
- **Reset priority:** `Reset` overrides `tick` in the same cycle. Reset mid-move returns the tray to `START_X` and IDLE with no residual speed.
- **Latency:**
  - `tray_position`, `tray_min`, `tray_max` and `speed` change on the `Clk` edge at which `tick` = 1, i.e. the first edge that samples `frame_clk` high.
  - Between ticks, all outputs are stable.
- **`wall_hit`:** high for exactly the cycle after the tick edge and low otherwise.
- **Keycode sampling:** keycode changes between ticks have no effect. Only the value present in the tick cycle counts.
- **First tick after reset:** if `frame_clk` is already high when `Reset` is released, `frame_q` = 0 makes the first post-reset cycle a tick. This is intended.

## Test plan
- **Reset:** assert `Reset` 2 cycles → `tray_position` = 288, `tray_max` = 351, `speed` = 0, `wall_hit` = 0.
- **Acceleration:** `keycode` = 07, 3 frame ticks → positions 289, 291, 294 and `speed` 1, 2, 3. Continue to 10 ticks → `speed` saturates at 8, with a per-tick delta of 8.
- **Long level:** `frame_clk` held high for 1000 cycles with `keycode` = 07 → exactly one position update.
- **Direction reversal:** at speed 4 moving R, `keycode` = 04 for one tick → `speed` = 1 and position decreases by 1. A following tick with `keycode` = 00 → IDLE, `speed` = 0, no movement.
- **Left wall:** start at 3 with `speed` 5 in MOVE_L, tick with 04 → `tray_position` = 0, `wall_hit` pulses 1 cycle, `speed` = 1. Next tick with 04 → position stays 0 and `wall_hit` pulses again.
- **Right wall and mid-move reset:**
  - Moving R at `speed` 8 from 570 → clamps to 576 with `tray_max` = 639.
  - Assert `Reset` in the same cycle as a tick → 288, IDLE, no `wall_hit`.
